// File: rtl/rename_table.sv
// rename_table
//   Speculative register alias table with a committed architectural copy.
//   Renames up to WIDTH instructions per cycle (slot 0 oldest). Each source
//   lookup returns either a ready value (valid=1) or the ROB tag of its
//   producer (valid=0, tag zero-extended to XLEN). Lookups are combinational;
//   all state changes happen on the rising clock edge.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   rename_valid/rd/robid/rs1/rs2 per-slot rename requests (packed, slot 0 in LSBs)
//   rat_rs1/rs2_valid/tagval      per-slot lookup results
//   wb_valid/error/robid/result   writeback broadcast
//   rob_commit_valid/rd/value     retirement into the architectural copy
//   rob_flush                     restore speculative state from the architectural copy
module rename_table #(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32,
  parameter int ROBW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        rename_valid,
  input  logic [5*WIDTH-1:0]      rename_rd,
  input  logic [ROBW*WIDTH-1:0]   rename_robid,
  input  logic [5*WIDTH-1:0]      rename_rs1,
  input  logic [5*WIDTH-1:0]      rename_rs2,
  output logic [WIDTH-1:0]        rat_rs1_valid,
  output logic [WIDTH-1:0]        rat_rs2_valid,
  output logic [XLEN*WIDTH-1:0]   rat_rs1_tagval,
  output logic [XLEN*WIDTH-1:0]   rat_rs2_tagval,
  input  logic                    wb_valid,
  input  logic                    wb_error,
  input  logic [ROBW-1:0]         wb_robid,
  input  logic [XLEN-1:0]         wb_result,
  input  logic                    rob_commit_valid,
  input  logic [4:0]              rob_commit_rd,
  input  logic [XLEN-1:0]         rob_commit_value,
  input  logic                    rob_flush
);

  // x0 is hardwired and has no storage, hence the 1..31 range.
  logic            spec_valid      [1:31];
  logic [XLEN-1:0] spec_tagval     [1:31];
  logic [XLEN-1:0] arch            [1:31];
  logic            spec_valid_nxt  [1:31];
  logic [XLEN-1:0] spec_tagval_nxt [1:31];
  logic [XLEN-1:0] arch_nxt        [1:31];

  logic            wb_hit;
  logic [4:0]      look_src;
  logic            look_valid;
  logic [XLEN-1:0] look_tagval;
  logic [4:0]      upd_rd;
  logic [4:0]      dep_rd;

  assign wb_hit = wb_valid && !wb_error;

  // Lookup: stored state, overridden by a matching writeback, overridden in
  // turn by the youngest older slot in the same group writing the source.
  always_comb begin
    rat_rs1_valid  = '0;
    rat_rs2_valid  = '0;
    rat_rs1_tagval = '0;
    rat_rs2_tagval = '0;
    look_src       = '0;
    look_valid     = 1'b1;
    look_tagval    = '0;
    dep_rd         = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int k = 0; k < 2; k++) begin
        look_src    = (k == 0) ? rename_rs1[i*5 +: 5] : rename_rs2[i*5 +: 5];
        look_valid  = 1'b1;
        look_tagval = '0;
        if (look_src != 5'd0) begin
          look_valid  = spec_valid[look_src];
          look_tagval = spec_tagval[look_src];
          if (!spec_valid[look_src] && wb_hit &&
              spec_tagval[look_src][ROBW-1:0] == wb_robid) begin
            look_valid  = 1'b1;
            look_tagval = wb_result;
          end
        end
        // Ascending scan so the youngest older producer is the one left standing.
        for (int j = 0; j < i; j++) begin
          dep_rd = rename_rd[j*5 +: 5];
          if (rename_valid[j] && dep_rd != 5'd0 && dep_rd == look_src) begin
            look_valid  = 1'b0;
            look_tagval = XLEN'(rename_robid[j*ROBW +: ROBW]);
          end
        end
        if (k == 0) begin
          rat_rs1_valid[i]              = look_valid;
          rat_rs1_tagval[i*XLEN +: XLEN] = look_tagval;
        end else begin
          rat_rs2_valid[i]              = look_valid;
          rat_rs2_tagval[i*XLEN +: XLEN] = look_tagval;
        end
      end
    end
  end

  // Next state. Commit is folded into arch_nxt first so that a flush in the
  // same cycle restores the post-commit value. Renames are applied after the
  // writeback so a same-cycle rename of the register wins, and in ascending
  // slot order so the youngest slot wins on a shared rd.
  always_comb begin
    arch_nxt        = arch;
    spec_valid_nxt  = spec_valid;
    spec_tagval_nxt = spec_tagval;
    upd_rd          = '0;
    if (rob_commit_valid && rob_commit_rd != 5'd0) begin
      arch_nxt[rob_commit_rd] = rob_commit_value;
    end
    if (rob_flush) begin
      for (int r = 1; r < 32; r++) begin
        spec_valid_nxt[r]  = 1'b1;
        spec_tagval_nxt[r] = arch_nxt[r];
      end
    end else begin
      if (wb_hit) begin
        for (int r = 1; r < 32; r++) begin
          if (!spec_valid[r] && spec_tagval[r][ROBW-1:0] == wb_robid) begin
            spec_valid_nxt[r]  = 1'b1;
            spec_tagval_nxt[r] = wb_result;
          end
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        upd_rd = rename_rd[i*5 +: 5];
        if (rename_valid[i] && upd_rd != 5'd0) begin
          spec_valid_nxt[upd_rd]  = 1'b0;
          spec_tagval_nxt[upd_rd] = XLEN'(rename_robid[i*ROBW +: ROBW]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        spec_valid[r]  <= 1'b1;
        spec_tagval[r] <= '0;
        arch[r]        <= '0;
      end
    end else begin
      spec_valid  <= spec_valid_nxt;
      spec_tagval <= spec_tagval_nxt;
      arch        <= arch_nxt;
    end
  end

endmodule

// File: tb/tb_rename_table.sv
// tb_rename_table
//   Directed scenarios for rename_table. Each scenario pushes expected lookup
//   results onto a scoreboard as it drives a cycle and pops/compares them at
//   the following falling edge.
module tb_rename_table;

  localparam int WIDTH = 2;
  localparam int XLEN  = 32;
  localparam int ROBW  = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [WIDTH-1:0]      rename_valid;
  logic [5*WIDTH-1:0]    rename_rd;
  logic [ROBW*WIDTH-1:0] rename_robid;
  logic [5*WIDTH-1:0]    rename_rs1;
  logic [5*WIDTH-1:0]    rename_rs2;
  logic [WIDTH-1:0]      rat_rs1_valid;
  logic [WIDTH-1:0]      rat_rs2_valid;
  logic [XLEN*WIDTH-1:0] rat_rs1_tagval;
  logic [XLEN*WIDTH-1:0] rat_rs2_tagval;
  logic                  wb_valid;
  logic                  wb_error;
  logic [ROBW-1:0]       wb_robid;
  logic [XLEN-1:0]       wb_result;
  logic                  rob_commit_valid;
  logic [4:0]            rob_commit_rd;
  logic [XLEN-1:0]       rob_commit_value;
  logic                  rob_flush;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: parallel queues (name, slot*2+source, {valid, tagval}).
  string       q_name [$];
  int          q_sel  [$];
  logic [32:0] q_exp  [$];

  string       nm;
  int          sel;
  logic [32:0] ex;
  logic [32:0] act;

  rename_table #(.WIDTH(WIDTH), .XLEN(XLEN), .ROBW(ROBW)) dut (
    .clk(clk), .rst(rst),
    .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_robid(rename_robid),
    .rename_rs1(rename_rs1), .rename_rs2(rename_rs2),
    .rat_rs1_valid(rat_rs1_valid), .rat_rs2_valid(rat_rs2_valid),
    .rat_rs1_tagval(rat_rs1_tagval), .rat_rs2_tagval(rat_rs2_tagval),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid), .wb_result(wb_result),
    .rob_commit_valid(rob_commit_valid), .rob_commit_rd(rob_commit_rd),
    .rob_commit_value(rob_commit_value), .rob_flush(rob_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] actual(input int s);
    int slot;
    slot = s >> 1;
    if ((s & 1) == 0) return {rat_rs1_valid[slot], rat_rs1_tagval[slot*XLEN +: XLEN]};
    else              return {rat_rs2_valid[slot], rat_rs2_tagval[slot*XLEN +: XLEN]};
  endfunction

  task automatic idle();
    rename_valid = '0; rename_rd = '0; rename_robid = '0;
    rename_rs1 = '0; rename_rs2 = '0;
    wb_valid = 1'b0; wb_error = 1'b0; wb_robid = '0; wb_result = '0;
    rob_commit_valid = 1'b0; rob_commit_rd = '0; rob_commit_value = '0;
    rob_flush = 1'b0;
  endtask

  task automatic ren(input int slot, input logic [4:0] rd, input logic [7:0] id);
    rename_valid[slot]          = 1'b1;
    rename_rd[slot*5 +: 5]      = rd;
    rename_robid[slot*ROBW +: ROBW] = id;
  endtask

  // Drive a source register and queue the lookup result it should produce.
  task automatic look(input int slot, input int k, input logic [4:0] r,
                      input logic v, input logic [31:0] tv, input string name);
    if (k == 0) rename_rs1[slot*5 +: 5] = r;
    else        rename_rs2[slot*5 +: 5] = r;
    q_name.push_back(name);
    q_sel.push_back(slot*2 + k);
    q_exp.push_back({v, tv});
  endtask

  task automatic test_reset();
    @(posedge clk); #1; idle();
    look(0, 0, 5'd5, 1'b1, 32'h0, "reset_s0_x5");
    look(0, 1, 5'd0, 1'b1, 32'h0, "reset_s0_x0");
    look(1, 0, 5'd0, 1'b1, 32'h0, "reset_s1_x0");
    look(1, 1, 5'd5, 1'b1, 32'h0, "reset_s1_x5");
    @(negedge clk);
    while (q_exp.size() != 0) begin
      nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
      act = actual(sel); n_cmp++;
      if (act !== ex) begin
        n_fail++;
        $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
      end
    end
  endtask

  task automatic test_bypass();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: ren(0, 5'd3, 8'h12);
        1: look(1, 0, 5'd3, 1'b0, 32'h12, "byp_busy");
        2: begin
          wb_valid = 1'b1; wb_robid = 8'h12; wb_result = 32'hDEADBEEF;
          look(1, 0, 5'd3, 1'b1, 32'hDEADBEEF, "byp_same_cycle");
        end
        default: begin
          look(0, 1, 5'd3, 1'b1, 32'hDEADBEEF, "byp_stored_s0");
          look(1, 1, 5'd3, 1'b1, 32'hDEADBEEF, "byp_stored_s1");
        end
      endcase
      @(negedge clk);
      while (q_exp.size() != 0) begin
        nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
        act = actual(sel); n_cmp++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
        end
      end
    end
  endtask

  task automatic test_intra_group();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: begin
          ren(0, 5'd7, 8'h20);
          look(1, 0, 5'd7, 1'b0, 32'h20, "grp_dep_x7");
          look(0, 0, 5'd7, 1'b1, 32'h0,  "grp_s0_no_self_dep");
          look(1, 1, 5'd0, 1'b1, 32'h0,  "grp_x0");
        end
        1: begin
          ren(0, 5'd9, 8'h21); ren(1, 5'd9, 8'h22);
          look(1, 0, 5'd9, 1'b0, 32'h21, "grp_dep_older_only");
          look(0, 0, 5'd7, 1'b0, 32'h20, "grp_x7_stored");
        end
        2: begin
          ren(0, 5'd0, 8'h23);
          look(1, 0, 5'd0, 1'b1, 32'h0,  "grp_rd0_no_dep");
          look(0, 0, 5'd9, 1'b0, 32'h22, "grp_youngest_wins");
        end
        3: begin
          rename_rd[4:0] = 5'd5; rename_robid[7:0] = 8'h24;
          look(1, 1, 5'd5, 1'b1, 32'h0, "grp_invalid_slot_no_dep");
        end
        default: look(0, 0, 5'd5, 1'b1, 32'h0, "grp_invalid_slot_no_write");
      endcase
      @(negedge clk);
      while (q_exp.size() != 0) begin
        nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
        act = actual(sel); n_cmp++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
        end
      end
    end
  endtask

  task automatic test_stale_wb();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: ren(0, 5'd4, 8'h30);
        1: begin
          ren(1, 5'd4, 8'h31);
          look(0, 0, 5'd4, 1'b0, 32'h30, "stale_first_tag");
          look(1, 1, 5'd4, 1'b0, 32'h30, "stale_own_rd_ignored");
        end
        2: begin
          wb_valid = 1'b1; wb_robid = 8'h30; wb_result = 32'h1234;
          look(0, 0, 5'd4, 1'b0, 32'h31, "stale_no_bypass");
        end
        3: look(0, 0, 5'd4, 1'b0, 32'h31, "stale_still_busy");
        4: ren(0, 5'd11, 8'h40);
        5: begin
          wb_valid = 1'b1; wb_robid = 8'h40; wb_result = 32'hABCD;
          ren(0, 5'd11, 8'h41);
          look(0, 0, 5'd11, 1'b1, 32'hABCD, "stale_bypass_s0");
          look(1, 0, 5'd11, 1'b0, 32'h41,   "stale_dep_beats_bypass");
        end
        default: look(0, 0, 5'd11, 1'b0, 32'h41, "stale_rename_beats_wb");
      endcase
      @(negedge clk);
      while (q_exp.size() != 0) begin
        nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
        act = actual(sel); n_cmp++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
        end
      end
    end
  endtask

  task automatic test_wb_error();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: ren(0, 5'd8, 8'h70);
        1: begin
          wb_valid = 1'b1; wb_error = 1'b1; wb_robid = 8'h70; wb_result = 32'h5;
          look(0, 0, 5'd8, 1'b0, 32'h70, "err_no_bypass");
        end
        2: look(0, 0, 5'd8, 1'b0, 32'h70, "err_stays_busy");
        3: begin
          wb_valid = 1'b1; wb_robid = 8'h70; wb_result = 32'hCAFE;
          look(1, 1, 5'd8, 1'b1, 32'hCAFE, "err_then_good_bypass");
        end
        default: look(0, 1, 5'd8, 1'b1, 32'hCAFE, "err_then_good_stored");
      endcase
      @(negedge clk);
      while (q_exp.size() != 0) begin
        nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
        act = actual(sel); n_cmp++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: begin ren(0, 5'd2, 8'h50); ren(1, 5'd6, 8'h51); end
        1: begin
          rob_commit_valid = 1'b1; rob_commit_rd = 5'd2; rob_commit_value = 32'h55;
          rob_flush = 1'b1;
          ren(0, 5'd13, 8'h60);
          wb_valid = 1'b1; wb_robid = 8'h51; wb_result = 32'h99;
          look(0, 0, 5'd6, 1'b1, 32'h99, "flush_cycle_lookup");
        end
        2: begin
          look(0, 0, 5'd2,  1'b1, 32'h55, "flush_commit_x2");
          look(0, 1, 5'd6,  1'b1, 32'h0,  "flush_x6_arch");
          look(1, 0, 5'd13, 1'b1, 32'h0,  "flush_drops_rename");
          look(1, 1, 5'd3,  1'b1, 32'h0,  "flush_drops_spec_value");
        end
        3: begin
          rob_commit_valid = 1'b1; rob_commit_rd = 5'd12; rob_commit_value = 32'h77;
          look(0, 0, 5'd12, 1'b1, 32'h0, "commit_no_spec_effect");
        end
        4: begin
          rob_flush = 1'b1;
          rob_commit_valid = 1'b1; rob_commit_rd = 5'd0; rob_commit_value = 32'hFFFF;
        end
        default: begin
          look(0, 0, 5'd12, 1'b1, 32'h77, "flush_restores_x12");
          look(1, 0, 5'd0,  1'b1, 32'h0,  "flush_x0_zero");
        end
      endcase
      @(negedge clk);
      while (q_exp.size() != 0) begin
        nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
        act = actual(sel); n_cmp++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; idle();
      case (c)
        0: ren(0, 5'd10, 8'h33);
        1: begin
          look(0, 0, 5'd10, 1'b0, 32'h33, "pre_reset_busy");
          look(0, 1, 5'd2,  1'b1, 32'h55, "pre_reset_x2");
          #1;
          // Pop the pre-reset checks before the reset lands mid-cycle.
          while (q_exp.size() != 0) begin
            nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
            act = actual(sel); n_cmp++;
            if (act !== ex) begin
              n_fail++;
              $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
            end
          end
          rst = 1'b1;
          look(0, 0, 5'd10, 1'b1, 32'h0, "async_reset_x10");
          look(0, 1, 5'd2,  1'b1, 32'h0, "async_reset_x2");
          #1;
          while (q_exp.size() != 0) begin
            nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
            act = actual(sel); n_cmp++;
            if (act !== ex) begin
              n_fail++;
              $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
            end
          end
          rst = 1'b0;
        end
        2: rob_flush = 1'b1;
        default: look(1, 0, 5'd2, 1'b1, 32'h0, "reset_cleared_arch");
      endcase
      @(negedge clk);
      while (q_exp.size() != 0) begin
        nm = q_name.pop_front(); sel = q_sel.pop_front(); ex = q_exp.pop_front();
        act = actual(sel); n_cmp++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s: got valid=%0b tagval=%h, want valid=%0b tagval=%h", nm, act[32], act[31:0], ex[32], ex[31:0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12 rst = 1'b0;
    test_reset();
    test_bypass();
    test_intra_group();
    test_stale_wb();
    test_wb_error();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
